// File: rtl/led_flasher_if.sv
// Event/LED bundle between event-producing logic and the LED flasher.
// The master drives event pulses; the slave (flasher) reports LED and queue status.
interface led_flasher_if #(
   parameter int PEND_W = 4
);
   logic              pulse;
   logic              led;
   logic              busy;
   logic [PEND_W-1:0] pending;
   logic              overflow;

   modport master (output pulse, input led, busy, pending, overflow);
   modport slave  (input pulse, output led, busy, pending, overflow);
endinterface

// File: rtl/led_flasher.sv
// Turns single-cycle event pulses into fixed-length LED flashes separated by a dark gap,
// queueing events that arrive mid-flash in a saturating counter and replaying them back-to-back.
module led_flasher #(
   parameter int ON_CYCLES  = 65536,
   parameter int GAP_CYCLES = 65536,
   parameter int PEND_W     = 4
) (
   input  logic          clk,
   input  logic          reset,
   led_flasher_if.slave  bus
);

   localparam int MAX_C = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
   localparam int TW    = $clog2(MAX_C) + 1;
   localparam logic [TW-1:0]     ON_LOAD  = TW'(ON_CYCLES - 1);
   localparam logic [TW-1:0]     GAP_LOAD = TW'(GAP_CYCLES - 1);
   localparam logic [PEND_W-1:0] PEND_MAX = '1;

   typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP} state_t;

   state_t            state_q, state_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic [PEND_W-1:0] pending_q, pending_d;
   logic              overflow_q, overflow_d;
   logic              led_q, led_d;
   logic              busy_q, busy_d;
   logic              pulse_used, queued_used, tmr_done;

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      pulse_used  = 1'b0;
      queued_used = 1'b0;
      tmr_done    = (timer_q == '0);

      // Timer counts down from (duration - 1); expiry marks the last cycle of a phase.
      case (state_q)
         S_IDLE: begin
            if (bus.pulse) begin
               state_d    = S_ON;
               timer_d    = ON_LOAD;
               pulse_used = 1'b1;
            end
         end
         S_ON: begin
            if (tmr_done) begin
               state_d = S_GAP;
               timer_d = GAP_LOAD;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         S_GAP: begin
            if (!tmr_done) begin
               timer_d = timer_q - TW'(1);
            end else if (pending_q != '0) begin
               state_d     = S_ON;
               timer_d     = ON_LOAD;
               queued_used = 1'b1;
            end else if (bus.pulse) begin
               state_d    = S_ON;
               timer_d    = ON_LOAD;
               pulse_used = 1'b1;
            end else begin
               state_d = S_IDLE;
               timer_d = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            timer_d = '0;
         end
      endcase

      pending_d  = pending_q;
      overflow_d = overflow_q;
      // A queued start with a simultaneous pulse swaps one event for another: no net change.
      if (queued_used && !bus.pulse) begin
         pending_d = pending_q - PEND_W'(1);
      end else if (bus.pulse && !pulse_used && !queued_used) begin
         if (pending_q == PEND_MAX) overflow_d = 1'b1;
         else                       pending_d  = pending_q + PEND_W'(1);
      end

      led_d  = (state_d == S_ON);
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         timer_q    <= '0;
         pending_q  <= '0;
         overflow_q <= 1'b0;
         led_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
         led_q      <= led_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.led      = led_q;
   assign bus.busy     = busy_q;
   assign bus.pending  = pending_q;
   assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_led_flasher.sv
// Bench for led_flasher: scripted scenarios plus random traffic, checked every cycle
// against a timeline model (flash start time, queued count, sticky overflow).
module tb_led_flasher;
   localparam int ON     = 4;
   localparam int GAP    = 3;
   localparam int PEND_W = 2;
   localparam int PMAX   = (1 << PEND_W) - 1;
   localparam int VW     = 3 + PEND_W;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_pass;
   int   cyc;

   // Model state: start cycle of the latest flash, queued events, overflow flag.
   int   m_start;
   int   m_q;
   logic m_ovf;

   led_flasher_if #(.PEND_W(PEND_W)) bus ();

   led_flasher #(.ON_CYCLES(ON), .GAP_CYCLES(GAP), .PEND_W(PEND_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [VW-1:0] dut_vec();
      return {bus.led, bus.busy, bus.pending, bus.overflow};
   endfunction

   function automatic logic [VW-1:0] exp_vec();
      logic e_led, e_busy;
      e_led  = (cyc >= m_start) && (cyc < m_start + ON);
      e_busy = (cyc >= m_start) && (cyc < m_start + ON + GAP);
      return {e_led, e_busy, PEND_W'(m_q), m_ovf};
   endfunction

   task automatic model_step(input logic p, input logic r);
      int  t;
      logic active, last_gap;
      t = cyc;
      if (r) begin
         m_start = -1000;
         m_q     = 0;
         m_ovf   = 1'b0;
      end else begin
         active   = (t < m_start + ON + GAP);
         last_gap = active && (t == m_start + ON + GAP - 1);
         if (!active) begin
            if (p) m_start = t + 1;
         end else if (last_gap && m_q > 0) begin
            m_q--;
            m_start = t + 1;
            if (p) m_q++;
         end else if (last_gap && p) begin
            m_start = t + 1;
         end else if (p) begin
            if (m_q == PMAX) m_ovf = 1'b1;
            else             m_q++;
         end
      end
   endtask

   task automatic tick(input logic p, input logic r);
      bus.pulse = p;
      reset     = r;
      model_step(p, r);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      logic [VW-1:0] got;
      for (int i = 0; i < 2; i++) begin
         tick(1'b1, 1'b1);
         got = dut_vec();
         n_chk++;
         if (got !== '0) $display("FAIL reset_hold cyc=%0d got=%h exp=%h", cyc, got, {VW{1'b0}});
         else n_pass++;
      end
      for (int i = 0; i < 10; i++) begin
         tick(1'b0, 1'b0);
         got = dut_vec();
         n_chk++;
         if (got !== exp_vec()) $display("FAIL reset_after cyc=%0d got=%h exp=%h", cyc, got, exp_vec());
         else if (bus.led !== 1'b0) $display("FAIL reset_noflash cyc=%0d led=%b exp=0", cyc, bus.led);
         else n_pass++;
      end
   endtask

   task automatic test_single();
      logic [VW-1:0] got;
      tick(1'b0, 1'b1);
      for (int i = 0; i < 14; i++) begin
         tick(i == 0, 1'b0);
         got = dut_vec();
         n_chk++;
         if (got !== exp_vec()) $display("FAIL single i=%0d got=%h exp=%h", i, got, exp_vec());
         else n_pass++;
      end
   endtask

   task automatic test_burst3();
      logic [VW-1:0] got;
      tick(1'b0, 1'b1);
      for (int i = 0; i < 26; i++) begin
         tick(i < 3, 1'b0);
         got = dut_vec();
         n_chk++;
         if (got !== exp_vec()) $display("FAIL burst3 i=%0d got=%h exp=%h", i, got, exp_vec());
         else n_pass++;
      end
   endtask

   task automatic test_saturate();
      logic [VW-1:0] got;
      logic prev_led;
      int   starts;
      tick(1'b0, 1'b1);
      prev_led = 1'b0;
      starts   = 0;
      for (int i = 0; i < 36; i++) begin
         tick(i < 5, 1'b0);
         got = dut_vec();
         if (bus.led === 1'b1 && prev_led === 1'b0) starts++;
         prev_led = bus.led;
         n_chk++;
         if (got !== exp_vec()) $display("FAIL saturate i=%0d got=%h exp=%h", i, got, exp_vec());
         else n_pass++;
      end
      n_chk++;
      if (starts != 4) $display("FAIL saturate_flashes got=%0d exp=4", starts);
      else n_pass++;
      n_chk++;
      if (bus.overflow !== 1'b1) $display("FAIL saturate_sticky got=%b exp=1", bus.overflow);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [VW-1:0] got;
      tick(1'b0, 1'b1);
      for (int i = 0; i < 16; i++) begin
         tick(i == 0 || i == 7, 1'b0);
         got = dut_vec();
         n_chk++;
         if (got !== exp_vec()) $display("FAIL back_to_back i=%0d got=%h exp=%h", i, got, exp_vec());
         else n_pass++;
         if (i == 7) begin
            n_chk++;
            if (bus.led !== 1'b1 || bus.pending !== '0)
               $display("FAIL b2b_restart led=%b pending=%0d exp led=1 pending=0", bus.led, bus.pending);
            else n_pass++;
         end
      end
   endtask

   task automatic test_reset_mid_on();
      logic [VW-1:0] got;
      tick(1'b0, 1'b1);
      for (int i = 0; i < 16; i++) begin
         tick(i < 2, i == 3);
         got = dut_vec();
         n_chk++;
         if (got !== exp_vec()) $display("FAIL reset_mid_on i=%0d got=%h exp=%h", i, got, exp_vec());
         else n_pass++;
         if (i == 3) begin
            n_chk++;
            if (got !== '0) $display("FAIL reset_mid_on_clear got=%h exp=%h", got, {VW{1'b0}});
            else n_pass++;
         end
      end
   endtask

   task automatic test_random();
      logic [VW-1:0] got;
      logic p, r;
      int   fails;
      fails = 0;
      tick(1'b0, 1'b1);
      for (int i = 0; i < 600; i++) begin
         p = ($urandom_range(99) < ((i / 100) % 2 == 0 ? 15 : 45));
         r = ($urandom_range(199) == 0);
         tick(p, r);
         got = dut_vec();
         n_chk++;
         if (got !== exp_vec()) begin
            if (fails < 10) $display("FAIL random i=%0d got=%h exp=%h", i, got, exp_vec());
            fails++;
         end else n_pass++;
      end
   endtask

   initial begin
      clk       = 1'b0;
      reset     = 1'b1;
      bus.pulse = 1'b0;
      n_chk     = 0;
      n_pass    = 0;
      cyc       = 0;
      m_start   = -1000;
      m_q       = 0;
      m_ovf     = 1'b0;
      #1;
      test_reset();
      test_single();
      test_burst3();
      test_saturate();
      test_back_to_back();
      test_reset_mid_on();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/led_flasher.md
# led_flasher

Output-side counterpart to the push-button input conditioning: takes single-cycle event pulses from core logic and turns each one into a human-visible LED flash of fixed length, followed by a mandatory dark gap. Events that arrive while a flash is in progress are queued in a saturating counter and replayed back-to-back, so fast bursts still show as distinct flashes. It sits between event-producing logic (e.g. one-shot button pulses, game/score events) and the board LED pins.

## Interface
- ON_CYCLES, 65536, LED-on duration per flash in clk cycles; must be >= 1
- GAP_CYCLES, 65536, LED-off gap after every flash in clk cycles; must be >= 1
- PEND_W, 4, width of the pending-event counter; max queued events = 2^PEND_W - 1
- clk  input  1  system clock; all logic on posedge
- reset  input  1  synchronous, active-high reset
- pulse  input  1  event request; every cycle it is high counts as one event
- led  output  1  LED drive, high during ON state only
- busy  output  1  high whenever state is not IDLE
- pending  output  PEND_W  queued events not yet started (excludes the flash currently shown)
- overflow  output  1  sticky; set when an event is dropped because pending is saturated

## Operation
- States: IDLE, ON, GAP. One timer, width clog2(max(ON_CYCLES, GAP_CYCLES)) + 1, loaded on each state entry.
- Reset (sampled high at a posedge): state IDLE, led 0, busy 0, pending 0, overflow 0, timer 0; pulse in that cycle ignored. Applies identically mid-ON or mid-GAP.
- "Request available" in a cycle = pending > 0 OR pulse = 1.
- IDLE: if pulse, go ON next cycle (pulse consumed directly, pending unchanged at 0). Otherwise stay.
- ON: led = 1 for exactly ON_CYCLES cycles, then GAP.
- GAP: led = 0 for exactly GAP_CYCLES cycles. On the last GAP cycle: if request available, go ON next cycle (no IDLE cycle in between); otherwise go IDLE.
- Pending update each cycle (not in reset): +1 if pulse and pulse is not being consumed this cycle; -1 if a queued event is consumed (start of ON from GAP with pending > 0); both at once leaves it unchanged. When starting ON from GAP, a queued event takes priority over a simultaneous pulse; that pulse is then queued (net pending unchanged).
- Saturation: pulse that would push pending above 2^PEND_W - 1 is dropped, pending holds at max, overflow set to 1 and held until reset.
- pulse held high for k cycles = k events (no edge detection here; caller supplies one-shot pulses).

## Timing
- All outputs registered; no combinational path from pulse to any output.
- pulse high in cycle N while IDLE -> led = 1, busy = 1 in cycles N+1 .. N+ON_CYCLES; led = 0 from N+ON_CYCLES+1.
- Flash period (start-to-start for queued events) = ON_CYCLES + GAP_CYCLES cycles exactly.
- Single isolated event: busy high ON_CYCLES + GAP_CYCLES cycles, low from cycle N+ON_CYCLES+GAP_CYCLES+1.
- pending reflects the update one cycle after the causing pulse/consumption.
- overflow rises the cycle after the dropping pulse.

## Test plan
Parameters for bench: ON_CYCLES=4, GAP_CYCLES=3, PEND_W=2.
- Reset held 2 cycles, pulse high throughout -> led=0, busy=0, pending=0, overflow=0 after release; no flash produced.
- Single pulse in cycle 10 -> led=1 cycles 11-14, led=0 from 15; busy=1 cycles 11-17, busy=0 at 18; pending stays 0.
- Pulses in cycles 10,11,12 -> pending=1 at 12, 2 at 13; flashes start at 11, 18, 25; pending=1 at 18, 0 at 25; busy drops at 32.
- Pulses in cycles 10-14 (five) -> pending saturates at 3 by cycle 14, overflow=1 from cycle 15; exactly 4 flashes (starts 11, 18, 25, 32).
- Single pulse cycle 10, second pulse in cycle 17 (last GAP cycle, pending=0) -> second flash starts cycle 18 with no IDLE gap; pending never leaves 0.
- Pulses cycles 10,11, reset in cycle 13 (mid-ON) -> cycle 14: led=0, busy=0, pending=0, overflow=0; no further flashes.
